// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad emulator and the scanner's test model:
// FSM encoding, line width and the key-to-line mapping.
package keypad_pkg;

    localparam int KP_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS_BNC = 3'd1,
        ST_HOLD      = 3'd2,
        ST_REL_BNC   = 3'd3,
        ST_GAP       = 3'd4
    } kp_state_e;

    typedef struct packed {
        logic [KP_W-1:0] row;
        logic [KP_W-1:0] col;
    } key_lines_t;

    // key[3:2] selects the row, key[1:0] the column; both lines are active-low one-hot.
    function automatic key_lines_t key_map(input logic [3:0] key);
        key_lines_t lines;
        lines.row = ~(4'b0001 << key[3:2]);
        lines.col = ~(4'b0001 << key[1:0]);
        return lines;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// Request and matrix lines between a keypad emulator and its driver
// (bench or scanner loopback).
interface keypad_if;
    logic                        req;
    logic [3:0]                  key;
    logic [15:0]                 hold_ms;
    logic [keypad_pkg::KP_W-1:0] row;
    logic [keypad_pkg::KP_W-1:0] col;
    logic                        busy;
    logic                        done;
    logic                        contact;

    modport master (output req, key, hold_ms, row, input col, busy, done, contact);
    modport slave  (input req, key, hold_ms, row, output col, busy, done, contact);
endinterface

// File: rtl/keypad_tick_timer.sv
// Loadable down-counter with zero flag; reloaded at every phase or
// bounce-half change of the keypad emulator.
module keypad_tick_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_r;

    // Load has priority; otherwise count down and stick at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/keypad_emulator.sv
// Responder end of a 4x4 row-scan keypad: plays back one timed key press,
// with contact bounce on press and release, on the active-low column lines.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int CLK_PER_MS    = 1,
    parameter int BOUNCE_CYCLES = 5,
    parameter int BOUNCE_HALF   = 1,
    parameter int GAP_MS        = 50
) (
    input  logic     clk,
    input  logic     rst_n,
    keypad_if.slave  kp
);

    localparam bit          HAS_BNC   = (BOUNCE_CYCLES != 0);
    localparam bit          HAS_GAP   = (GAP_MS != 0);
    localparam logic [15:0] LAST_HALF = HAS_BNC ? 16'(2 * BOUNCE_CYCLES - 1) : 16'd0;
    localparam logic [31:0] HALF_LOAD = 32'(BOUNCE_HALF - 1);
    localparam logic [31:0] GAP_CYC   = 32'(GAP_MS) * 32'(CLK_PER_MS);
    localparam logic [31:0] GAP_LOAD  = HAS_GAP ? (GAP_CYC - 32'd1) : 32'd0;

    kp_state_e   state_r, state_nxt_s;
    logic [15:0] half_r, half_nxt_s;
    logic        contact_r, contact_nxt_s;
    logic        busy_r, busy_nxt_s;
    logic        done_r, done_nxt_s;
    logic [3:0]  key_r;
    logic [15:0] hold_r;
    logic        accept_s;
    logic        tmr_load_s;
    logic [31:0] tmr_val_s;
    logic        tmr_zero_s;
    key_lines_t  lines_s;

    // 16x16 product always fits the 32-bit timer; zero hold is stretched to 1 ms.
    function automatic logic [31:0] hold_cycles(input logic [15:0] h);
        logic [15:0] eff;
        eff = (h == 16'd0) ? 16'd1 : h;
        return 32'(eff) * 32'(CLK_PER_MS);
    endfunction

    keypad_tick_timer #(.W(32)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    // Next-state and registered-output logic of the press sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        half_nxt_s    = half_r;
        contact_nxt_s = contact_r;
        busy_nxt_s    = busy_r;
        done_nxt_s    = 1'b0;
        accept_s      = 1'b0;
        tmr_load_s    = 1'b0;
        tmr_val_s     = 32'd0;
        case (state_r)
            ST_IDLE: begin
                busy_nxt_s    = 1'b0;
                contact_nxt_s = 1'b0;
                // A req coinciding with the done pulse is deliberately dropped.
                if (kp.req && !done_r) begin
                    accept_s      = 1'b1;
                    busy_nxt_s    = 1'b1;
                    contact_nxt_s = 1'b1;
                    tmr_load_s    = 1'b1;
                    half_nxt_s    = 16'd0;
                    if (HAS_BNC) begin
                        state_nxt_s = ST_PRESS_BNC;
                        tmr_val_s   = HALF_LOAD;
                    end else begin
                        state_nxt_s = ST_HOLD;
                        tmr_val_s   = hold_cycles(kp.hold_ms) - 32'd1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRESS_BNC: begin
                if (tmr_zero_s && (half_r == LAST_HALF)) begin
                    state_nxt_s   = ST_HOLD;
                    contact_nxt_s = 1'b1;
                    tmr_load_s    = 1'b1;
                    tmr_val_s     = hold_cycles(hold_r) - 32'd1;
                end else if (tmr_zero_s) begin
                    half_nxt_s    = half_r + 16'd1;
                    contact_nxt_s = half_r[0];
                    tmr_load_s    = 1'b1;
                    tmr_val_s     = HALF_LOAD;
                end else begin
                    state_nxt_s = ST_PRESS_BNC;
                end
            end
            ST_HOLD: begin
                if (tmr_zero_s && HAS_BNC) begin
                    state_nxt_s   = ST_REL_BNC;
                    half_nxt_s    = 16'd0;
                    contact_nxt_s = 1'b0;
                    tmr_load_s    = 1'b1;
                    tmr_val_s     = HALF_LOAD;
                end else if (tmr_zero_s && HAS_GAP) begin
                    state_nxt_s   = ST_GAP;
                    contact_nxt_s = 1'b0;
                    tmr_load_s    = 1'b1;
                    tmr_val_s     = GAP_LOAD;
                end else if (tmr_zero_s) begin
                    state_nxt_s   = ST_IDLE;
                    contact_nxt_s = 1'b0;
                    busy_nxt_s    = 1'b0;
                    done_nxt_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_REL_BNC: begin
                if (tmr_zero_s && (half_r == LAST_HALF) && HAS_GAP) begin
                    state_nxt_s   = ST_GAP;
                    contact_nxt_s = 1'b0;
                    tmr_load_s    = 1'b1;
                    tmr_val_s     = GAP_LOAD;
                end else if (tmr_zero_s && (half_r == LAST_HALF)) begin
                    state_nxt_s   = ST_IDLE;
                    contact_nxt_s = 1'b0;
                    busy_nxt_s    = 1'b0;
                    done_nxt_s    = 1'b1;
                end else if (tmr_zero_s) begin
                    half_nxt_s    = half_r + 16'd1;
                    contact_nxt_s = ~half_r[0];
                    tmr_load_s    = 1'b1;
                    tmr_val_s     = HALF_LOAD;
                end else begin
                    state_nxt_s = ST_REL_BNC;
                end
            end
            ST_GAP: begin
                if (tmr_zero_s) begin
                    state_nxt_s   = ST_IDLE;
                    contact_nxt_s = 1'b0;
                    busy_nxt_s    = 1'b0;
                    done_nxt_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                contact_nxt_s = 1'b0;
                busy_nxt_s    = 1'b0;
            end
        endcase
    end

    // State, output and request-latch registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            half_r    <= 16'd0;
            contact_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            key_r     <= 4'd0;
            hold_r    <= 16'd0;
        end else begin
            state_r   <= state_nxt_s;
            half_r    <= half_nxt_s;
            contact_r <= contact_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            if (accept_s) begin
                key_r  <= kp.key;
                hold_r <= kp.hold_ms;
            end
        end
    end

    // Column response follows the row strobe in the same cycle; X rows fall to the else arm.
    always_comb begin
        lines_s = key_map(key_r);
        if (contact_r && (kp.row == lines_s.row)) begin
            kp.col = lines_s.col;
        end else begin
            kp.col = 4'b1111;
        end
    end

    assign kp.busy    = busy_r;
    assign kp.done    = done_r;
    assign kp.contact = contact_r;

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized scoreboard bench for keypad_emulator: expected press sequences are
// queued at request time and checked by a monitor on busy/done.
module tb_keypad_emulator;

    localparam int CPM = 2;
    localparam int BC  = 3;
    localparam int BH  = 2;
    localparam int GM  = 5;
    localparam int P   = 2 * BC * BH;

    typedef struct {
        int key;
        int hc;
        int exp_rise;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    keypad_if kp();

    keypad_emulator #(.CLK_PER_MS(CPM), .BOUNCE_CYCLES(BC), .BOUNCE_HALF(BH), .GAP_MS(GM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    txn_t q[$];
    txn_t cur;
    bit   in_txn = 1'b0;
    bit   spur = 1'b0;
    int   idx = 0;
    int   bad_contact = 0;
    int   bad_col = 0;
    int   idle_bad = 0;
    int   last_done = 0;
    int   rises = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] row_low(input int k);
        return 4'(15 - (1 << (k / 4)));
    endfunction

    function automatic logic [3:0] col_low(input int k);
        return 4'(15 - (1 << (k % 4)));
    endfunction

    // Contact state i cycles after busy rose: press bounce, hold, release bounce, gap.
    function automatic bit exp_contact(input int hc, input int i);
        int j;
        j = i;
        if (j < P) return ((j / BH) % 2) == 0;
        j = j - P;
        if (j < hc) return 1'b1;
        j = j - hc;
        if (j < P) return ((j / BH) % 2) == 1;
        return 1'b0;
    endfunction

    function automatic int hold_cyc(input int h);
        return ((h == 0) ? 1 : h) * CPM;
    endfunction

    // Row strobe driver: half of the time the active key's row, otherwise anything.
    initial begin
        logic [3:0] pats [8];
        pats = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'b1100, 4'b0000, 4'b1010};
        kp.row = 4'b1111;
        forever begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 1) == 0 && q.size() != 0) kp.row = row_low(q[0].key);
            else kp.row = pats[$urandom_range(0, 7)];
        end
    end

    // Monitor: follows busy/done and scores each sequence against the queued expectation.
    always @(negedge clk) begin
        logic [3:0] exp_col;
        if (!rst_n) begin
            in_txn = 1'b0;
        end else begin
            if (!kp.busy) spur = 1'b0;
            if (kp.busy && !in_txn) begin
                if (q.size() == 0) begin
                    if (!spur) check("busy_unexpected", 1, 0);
                    spur = 1'b1;
                end else begin
                    cur = q[0];
                    in_txn = 1'b1;
                    idx = 0;
                    bad_contact = 0;
                    bad_col = 0;
                    rises++;
                    check("busy_rise_cycle", cyc, (cur.exp_rise >= 0) ? cur.exp_rise : last_done + 2);
                end
            end
            if (kp.busy && in_txn) begin
                if (kp.contact !== exp_contact(cur.hc, idx)) bad_contact++;
                exp_col = 4'b1111;
                if (kp.contact === 1'b1 && kp.row == row_low(cur.key)) exp_col = col_low(cur.key);
                if (kp.col !== exp_col) bad_col++;
                idx++;
            end else if (!kp.busy) begin
                if (kp.contact !== 1'b0 || kp.col !== 4'b1111) idle_bad++;
            end
            if (kp.done) begin
                if (!in_txn) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    check("busy_length", idx, 2 * P + cur.hc + GM * CPM);
                    check("contact_trace_bad_cycles", bad_contact, 0);
                    check("col_map_bad_cycles", bad_col, 0);
                    check("busy_low_at_done", int'(kp.busy), 0);
                    void'(q.pop_front());
                    in_txn = 1'b0;
                    last_done = cyc;
                end
            end else if (!kp.busy && in_txn) begin
                check("busy_dropped_without_done", 1, 0);
                void'(q.pop_front());
                in_txn = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((kp.busy || kp.done || q.size() != 0) && n < 20000);
        check("wait_idle_timeout", int'(n >= 20000), 0);
    endtask

    task automatic press(input int k, input int h);
        txn_t t;
        wait_idle();
        kp.key = 4'(k);
        kp.hold_ms = 16'(h);
        kp.req = 1'b1;
        t.key = k;
        t.hc = hold_cyc(h);
        t.exp_rise = cyc + 1;
        q.push_back(t);
        @(posedge clk);
        #1;
        kp.req = 1'b0;
        kp.key = 4'($urandom);
        kp.hold_ms = 16'($urandom);
    endtask

    task automatic wait_idx(input int target);
        int n;
        n = 0;
        while (!(in_txn && idx >= target) && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_idx_timeout", int'(n >= 20000), 0);
    endtask

    initial begin
        txn_t t;
        int   n;
        int   target;
        kp.req = 1'b0;
        kp.key = 4'd0;
        kp.hold_ms = 16'd0;
        #1;
        check("reset_col", int'(kp.col), 15);
        check("reset_busy", int'(kp.busy), 0);
        check("reset_done", int'(kp.done), 0);
        check("reset_contact", int'(kp.contact), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        press(6, 100);
        press(4, 0);
        press(2, 3000);

        // req pulsed during HOLD must be ignored
        press(9, 50);
        wait_idx(P + 6);
        @(posedge clk);
        #1;
        kp.req = 1'b1;
        kp.key = 4'd3;
        kp.hold_ms = 16'd7;
        @(posedge clk);
        #1;
        kp.req = 1'b0;

        for (int k = 0; k < 16; k++) press(k, $urandom_range(0, 30));

        // req held across done: ignored in the done cycle, accepted one cycle later
        wait_idle();
        kp.key = 4'd11;
        kp.hold_ms = 16'd5;
        kp.req = 1'b1;
        t.key = 11;
        t.hc = hold_cyc(5);
        t.exp_rise = cyc + 1;
        q.push_back(t);
        t.exp_rise = -1;
        q.push_back(t);
        target = rises + 2;
        n = 0;
        while (rises < target && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("second_accept_timeout", int'(n >= 2000), 0);
        kp.req = 1'b0;

        // asynchronous reset during HOLD aborts the sequence with no done
        press(13, 40);
        wait_idx(P + 5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_col", int'(kp.col), 15);
        check("abort_busy", int'(kp.busy), 0);
        check("abort_contact", int'(kp.contact), 0);
        check("abort_done", int'(kp.done), 0);
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        press(15, 7);

        for (int i = 0; i < 8; i++) begin
            press($urandom_range(0, 15), $urandom_range(0, 40));
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end

        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        check("idle_bad_cycles", idle_bad, 0);
        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
Synthesizable model of a 4x4 matrix keypad: the responder end of the row-scan / column-sense interface that the Keyboard scanner drives. A request port accepts a key code and a hold time. The block then plays back a timed key press on the column lines, including contact bounce on both press and release. It drives col combinationally from the scanner's active-low row strobe, so the scanner sees the column response in the same cycle. It is used as a self-checking stimulus source in benches and in on-board loopback tests of the scanner.

Parameters:
CLK_PER_MS, 1, clk cycles per millisecond tick; legal range 1..65535.
BOUNCE_CYCLES, 5, number of open/closed bounce pairs on press and again on release; 0 disables bounce.
BOUNCE_HALF, 1, clk cycles per bounce half-period; must be at least 1.
GAP_MS, 50, guaranteed open time after release bounce, in ms, before done is pulsed.

Ports:
clk  in  1  system clock, rising-edge.
rst_n  in  1  asynchronous active-low reset.
row  in  4  scanner row strobe, active-low one-hot (1110 = row 0 ... 0111 = row 3).
req  in  1  start request; sampled only while busy=0.
key  in  4  key code 0..15; key[3:2] = row index, key[1:0] = column index.
hold_ms  in  16  closed time after press bounce, in ms; 0 is treated as 1.
col  out  4  column sense, active-low.
busy  out  1  high from the cycle after an accepted req until done.
done  out  1  one-cycle pulse at the end of the sequence.
contact  out  1  current contact state (1 = closed), for bench visibility.

Behaviour:
- Reset, asynchronous: state=IDLE, contact=0, busy=0, done=0, all counters cleared. col=1111 immediately; there is no wait for a clock edge.
- col, combinational:
  - If contact=1 and row equals the one-hot pattern for latched key[3:2], then col = ~(4'b0001 << key[1:0]); key 0 gives 1110, key 3 gives 0111.
  - Otherwise col=1111. This includes row=1111, any multi-zero row pattern, and X.
- FSM states: IDLE -> PRESS_BNC -> HOLD -> REL_BNC -> GAP -> IDLE.
- IDLE:
  - If req=1 at edge N, key and hold_ms are latched at edge N.
  - At N+1: busy=1, state=PRESS_BNC, or HOLD directly if BOUNCE_CYCLES=0.
- PRESS_BNC:
  - Lasts 2*BOUNCE_CYCLES half-periods of BOUNCE_HALF cycles each.
  - contact=1 in even halves (0, 2, ...) and 0 in odd halves.
- HOLD:
  - contact=1 for exactly max(hold_ms,1)*CLK_PER_MS cycles.
  - The tick counter is 32 bits and must not overflow at the maximum product 65535*65535.
- REL_BNC:
  - Lasts 2*BOUNCE_CYCLES half-periods.
  - contact=0 in even halves and 1 in odd halves.
  - Skipped if BOUNCE_CYCLES=0.
- GAP:
  - contact=0 for GAP_MS*CLK_PER_MS cycles; GAP_MS=0 gives zero cycles.
  - The cycle after GAP ends: done=1 for one cycle, busy=0 in the same cycle, state=IDLE.
- req while busy=1 is ignored, not queued.
- req in the same cycle as done is ignored. A new press can be accepted one cycle after done.
- Latched key and hold_ms are stable for the whole sequence; changes on key or hold_ms while busy have no effect.
- rst_n low mid-sequence aborts the sequence: no done pulse, col=1111 at once.
- Total busy length = 4*BOUNCE_CYCLES*BOUNCE_HALF + max(hold_ms,1)*CLK_PER_MS + GAP_MS*CLK_PER_MS cycles.

Decomposition:
- Shared package keypad_pkg holds:
  - the FSM state encoding (3 bits);
  - the key-to-row and key-to-column one-hot-low mapping function;
  - row/col width constant 4.
- The Keyboard scanner's test model reuses the same mapping function.
- One sub-module: keypad_tick_timer, a loadable down-counter with a zero flag. It is instantiated once and reloaded at each phase change, serving both bounce half-periods and the HOLD/GAP durations.

Test Plan:
- Basic press (CLK_PER_MS=1, BOUNCE_CYCLES=0, GAP_MS=50): req with key=6, hold_ms=100.
  - busy rises the next cycle and contact=1 for exactly 100 cycles.
  - col=1011 only while row=1101; col=1111 for other rows.
  - done pulses once, 150 cycles after busy rose.
- Full key map: sequence keys 0..15 with hold 20 against the Keyboard scanner → scanner num equals key each time, and no mismatch over all 16 keys.
- Bounce (BOUNCE_CYCLES=10, BOUNCE_HALF=1): key=5, hold=200.
  - contact toggles 20 times before the steady-closed period and 20 times after it.
  - The scanner reports exactly one press with num=5.
- Long press: hold_ms=3000, key=2 → contact=1 for 3000 cycles, a single scanner press event, done after 3050 cycles.
- Busy and boundary cases:
  - req pulsed mid-HOLD is ignored: the sequence length is unchanged and there is one done.
  - hold_ms=0 produces a 1 ms hold.
  - row=1100 gives col=1111.
- Reset mid-HOLD: drop rst_n while contact=1 → col=1111 and busy=0 immediately (asynchronous), no done pulse, and the next req after release behaves normally.
